// File: rtl/slam_stage_host.sv
// Host-side sequencer for the SLAM accelerator stage interface: issues stage
// commands with settled operands, waits for stage_rdy, and streams state-vector readback.
module slam_stage_host #(
  parameter int DW     = 32,
  parameter int SVL_W  = 10,
  parameter int RD_LAT = 2,
  parameter int GAP    = 2,
  parameter int TMO_W  = 20
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DW-1:0]    cmd_a,
  input  logic [DW-1:0]    cmd_b,
  input  logic [SVL_W-1:0] sv_len,
  output logic [2:0]       stage_val,
  input  logic             stage_rdy,
  output logic [DW-1:0]    vlr,
  output logic [DW-1:0]    alpha,
  output logic [DW-1:0]    rk,
  output logic [DW-1:0]    phi,
  output logic             state_vector_start,
  input  logic [DW-1:0]    state_vector,
  output logic             sv_valid,
  output logic             sv_last,
  output logic [DW-1:0]    sv_data,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [2:0]       state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is only raised in S_IDLE once the inter-command gap has elapsed.

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_RD_START, S_RD_WAIT, S_RD_STREAM
  } state_t;

  localparam logic [2:0] OP_PRD   = 3'd1;
  localparam logic [2:0] OP_NEW   = 3'd2;
  localparam logic [2:0] OP_UPD   = 3'd3;
  localparam logic [2:0] OP_ASSOC = 3'd4;
  localparam logic [2:0] OP_READ  = 3'd5;

  localparam int GAP_W  = $clog2(GAP + 1);
  localparam int WAIT_W = $clog2(RD_LAT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - 1'b1;

  state_t             state;
  logic [2:0]         op_q;
  logic [SVL_W-1:0]   len_q;
  logic [SVL_W-1:0]   beat_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               first_q;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state              <= S_IDLE;
      op_q               <= '0;
      len_q              <= '0;
      beat_cnt           <= '0;
      gap_cnt            <= '0;
      wait_cnt           <= '0;
      tmo_cnt            <= '0;
      first_q            <= 1'b0;
      cmd_ready          <= 1'b0;
      stage_val          <= '0;
      vlr                <= '0;
      alpha              <= '0;
      rk                 <= '0;
      phi                <= '0;
      state_vector_start <= 1'b0;
      sv_valid           <= 1'b0;
      sv_last            <= 1'b0;
      sv_data            <= '0;
      busy               <= 1'b0;
      err_illegal        <= 1'b0;
      err_timeout        <= 1'b0;
    end else begin
      err_illegal        <= 1'b0;
      err_timeout        <= 1'b0;
      state_vector_start <= 1'b0;
      sv_valid           <= 1'b0;
      sv_last            <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            len_q     <= sv_len;
            case (cmd_op)
              OP_PRD: begin
                vlr   <= cmd_a;
                alpha <= cmd_b;
                busy  <= 1'b1;
                state <= S_SETUP;
              end
              OP_NEW, OP_UPD, OP_ASSOC: begin
                rk    <= cmd_a;
                phi   <= cmd_b;
                busy  <= 1'b1;
                state <= S_SETUP;
              end
              OP_READ: begin
                state_vector_start <= 1'b1;
                busy               <= 1'b1;
                state              <= S_RD_START;
              end
              default: begin
                err_illegal <= 1'b1;
                gap_cnt     <= GAP_W'(GAP);
              end
            endcase
          end else if (gap_cnt != '0) begin
            gap_cnt   <= gap_cnt - 1'b1;
            cmd_ready <= (gap_cnt == GAP_W'(1));
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          stage_val <= op_q;
          tmo_cnt   <= '0;
          first_q   <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          // First ISSUE cycle may still see the previous command's rdy level.
          first_q <= 1'b0;
          tmo_cnt <= tmo_cnt + 1'b1;
          if ((!first_q && stage_rdy) || tmo_cnt == TMO_LAST) begin
            err_timeout <= !(!first_q && stage_rdy);
            stage_val   <= '0;
            busy        <= 1'b0;
            gap_cnt     <= GAP_W'(GAP);
            state       <= S_IDLE;
          end
        end
        S_RD_START: begin
          beat_cnt <= '0;
          if (len_q == '0) begin
            busy    <= 1'b0;
            gap_cnt <= GAP_W'(GAP);
            state   <= S_IDLE;
          end else if (RD_LAT <= 1) begin
            state <= S_RD_STREAM;
          end else begin
            wait_cnt <= WAIT_W'(RD_LAT - 1);
            state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt <= WAIT_W'(1)) state <= S_RD_STREAM;
        end
        S_RD_STREAM: begin
          sv_valid <= 1'b1;
          sv_data  <= state_vector;
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == len_q - 1'b1) begin
            sv_last <= 1'b1;
            busy    <= 1'b0;
            gap_cnt <= GAP_W'(GAP);
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slam_stage_host.sv
// Directed bench for slam_stage_host: stage command sequencing, operand holding,
// readback streaming, illegal ops, timeout and mid-stream reset.
module tb_slam_stage_host;
  localparam int DW = 32, SVL_W = 10, RD_LAT = 2, GAP = 2, TMO_W = 4;

  logic             clk = 1'b0;
  logic             sys_rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [DW-1:0]    cmd_a = '0, cmd_b = '0;
  logic [SVL_W-1:0] sv_len = '0;
  logic [2:0]       stage_val;
  logic             stage_rdy = 1'b0;
  logic [DW-1:0]    vlr, alpha, rk, phi;
  logic             state_vector_start;
  logic [DW-1:0]    state_vector = '0;
  logic             sv_valid, sv_last;
  logic [DW-1:0]    sv_data;
  logic             busy, err_illegal, err_timeout;
  logic [2:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slam_stage_host #(.DW(DW), .SVL_W(SVL_W), .RD_LAT(RD_LAT), .GAP(GAP), .TMO_W(TMO_W)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .sv_len(sv_len),
    .stage_val(stage_val), .stage_rdy(stage_rdy), .vlr(vlr), .alpha(alpha),
    .rk(rk), .phi(phi), .state_vector_start(state_vector_start),
    .state_vector(state_vector), .sv_valid(sv_valid), .sv_last(sv_last),
    .sv_data(sv_data), .busy(busy), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_wait got %b exp 1", tag, cmd_ready); end
  endtask

  // Presents one command for a single cycle; returns at the first cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [SVL_W-1:0] len);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; sv_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 sys_rst_n = 1'b0;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL rst_stage_val got %0d exp 0", stage_val); end
    checks++; if ({busy, sv_valid, sv_last, state_vector_start, err_illegal, err_timeout} !== 6'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 000000", {busy, sv_valid, sv_last, state_vector_start, err_illegal, err_timeout});
    end
    checks++; if ({vlr, alpha, rk, phi, sv_data} !== '0) begin errors++; $display("FAIL rst_data got nonzero exp 0"); end
    sys_rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_prd();
    wait_ready("prd");
    issue(3'd1, 32'h0001_0000, 32'h0000_8000, '0);
    checks++; if (vlr !== 32'h0001_0000) begin errors++; $display("FAIL prd_vlr got %h exp 00010000", vlr); end
    checks++; if (alpha !== 32'h0000_8000) begin errors++; $display("FAIL prd_alpha got %h exp 00008000", alpha); end
    checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL prd_setup_val got %0d exp 0", stage_val); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL prd_busy got %b%b exp 10", busy, cmd_ready); end
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick(); else tick();
      checks++; if (stage_val !== 3'd1) begin errors++; $display("FAIL prd_issue_val cyc %0d got %0d exp 1", i, stage_val); end
    end
    stage_rdy = 1'b1;
    tick();
    stage_rdy = 1'b0;
    checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL prd_done_val got %0d exp 0", stage_val); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL prd_gap0 got %b%b exp 00", busy, cmd_ready); end
    checks++; if (vlr !== 32'h0001_0000) begin errors++; $display("FAIL prd_vlr_hold got %h exp 00010000", vlr); end
    tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL prd_gap1 got %b exp 0", cmd_ready); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL prd_gap_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_operand_hold();
    wait_ready("upd");
    issue(3'd3, 32'h10, 32'h20, '0);
    checks++; if (rk !== 32'h10 || phi !== 32'h20) begin errors++; $display("FAIL upd_rkphi got %h/%h exp 10/20", rk, phi); end
    checks++; if (vlr !== 32'h0001_0000) begin errors++; $display("FAIL upd_vlr_hold got %h exp 00010000", vlr); end
    tick();
    checks++; if (stage_val !== 3'd3) begin errors++; $display("FAIL upd_issue_val got %0d exp 3", stage_val); end
    // Commands offered while busy must be ignored.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 32'hbad; cmd_b = 32'hbad;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rk !== 32'h10 || cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ignore got rk %h rdy %b exp 10/0", rk, cmd_ready); end
    end
    cmd_valid = 1'b0;
    stage_rdy = 1'b1;
    tick();
    stage_rdy = 1'b0;
    checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL upd_done_val got %0d exp 0", stage_val); end
    wait_ready("prd2");
    issue(3'd1, 32'h2, 32'h3, '0);
    checks++; if (vlr !== 32'h2 || alpha !== 32'h3) begin errors++; $display("FAIL prd2_vlr got %h/%h exp 2/3", vlr, alpha); end
    checks++; if (rk !== 32'h10 || phi !== 32'h20) begin errors++; $display("FAIL prd2_rk_hold got %h/%h exp 10/20", rk, phi); end
    tick(); tick();
    stage_rdy = 1'b1;
    tick();
    stage_rdy = 1'b0;
    checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL prd2_done_val got %0d exp 0", stage_val); end
  endtask

  task automatic test_stale_rdy();
    wait_ready("stale");
    stage_rdy = 1'b1;
    issue(3'd2, 32'h5, 32'h6, '0);
    checks++; if (stage_val !== 3'd0 || rk !== 32'h5) begin errors++; $display("FAIL stale_setup got %0d/%h exp 0/5", stage_val, rk); end
    tick();
    checks++; if (stage_val !== 3'd2) begin errors++; $display("FAIL stale_issue0 got %0d exp 2", stage_val); end
    tick();
    checks++; if (stage_val !== 3'd2) begin errors++; $display("FAIL stale_guard got %0d exp 2", stage_val); end
    tick();
    stage_rdy = 1'b0;
    checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL stale_done got %0d exp 0", stage_val); end
  endtask

  task automatic test_illegal();
    wait_ready("illegal");
    issue(3'd6, 32'h77, 32'h77, '0);
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse got %b exp 1", err_illegal); end
    checks++; if (stage_val !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL illegal_state got val %0d busy %b rdy %b exp 0/0/0", stage_val, busy, cmd_ready);
    end
    checks++; if (rk !== 32'h5 || vlr !== 32'h2) begin errors++; $display("FAIL illegal_operands got %h/%h exp 5/2", rk, vlr); end
    tick();
    checks++; if (err_illegal !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL illegal_gap got %b%b exp 00", err_illegal, cmd_ready); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || stage_val !== 3'd0) begin errors++; $display("FAIL illegal_ready got %b/%0d exp 1/0", cmd_ready, stage_val); end
  endtask

  task automatic test_read(input int len);
    int beats = 0, starts = 0;
    logic [DW-1:0] exp_d;
    wait_ready("read");
    issue(3'd5, '0, '0, SVL_W'(len));
    for (int i = 0; i <= len + 4; i++) begin
      if (state_vector_start === 1'b1) starts++;
      checks++; if (state_vector_start !== (i == 0)) begin errors++; $display("FAIL read%0d_start cyc %0d got %b exp %b", len, i, state_vector_start, i == 0); end
      checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL read%0d_stage_val cyc %0d got %0d exp 0", len, i, stage_val); end
      checks++; if (sv_valid !== (i >= 3 && i - 3 < len)) begin errors++; $display("FAIL read%0d_valid cyc %0d got %b exp %b", len, i, sv_valid, i >= 3 && i - 3 < len); end
      if (i >= 3 && i - 3 < len) begin
        exp_d = DW'(100 + i - 3);
        checks++; if (sv_data !== exp_d) begin errors++; $display("FAIL read%0d_data cyc %0d got %0d exp %0d", len, i, sv_data, exp_d); end
        checks++; if (sv_last !== (i - 3 == len - 1)) begin errors++; $display("FAIL read%0d_last cyc %0d got %b exp %b", len, i, sv_last, i - 3 == len - 1); end
      end
      if (sv_valid === 1'b1) beats++;
      state_vector = (i >= 2 && i - 2 < len) ? DW'(100 + i - 2) : 32'hdead_beef;
      tick();
    end
    checks++; if (beats != len || starts != 1) begin errors++; $display("FAIL read%0d_count got beats %0d starts %0d exp %0d/1", len, beats, starts, len); end
  endtask

  task automatic test_timeout();
    int n = 0;
    wait_ready("timeout");
    issue(3'd4, 32'h7, 32'h8, '0);
    checks++; if (stage_val !== 3'd0) begin errors++; $display("FAIL tmo_setup got %0d exp 0", stage_val); end
    while (n < 100) begin
      tick();
      if (stage_val === 3'd4) n++; else break;
    end
    checks++; if (n != 15) begin errors++; $display("FAIL tmo_cycles got %0d exp 15", n); end
    checks++; if (err_timeout !== 1'b1 || stage_val !== 3'd0) begin errors++; $display("FAIL tmo_pulse got %b/%0d exp 1/0", err_timeout, stage_val); end
    tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width got %b exp 0", err_timeout); end
  endtask

  task automatic test_reset_mid_stream();
    wait_ready("rst_mid");
    issue(3'd5, '0, '0, SVL_W'(7));
    for (int i = 0; i < 5; i++) begin
      state_vector = (i >= 2) ? DW'(100 + i - 2) : 32'hdead_beef;
      tick();
    end
    checks++; if (sv_valid !== 1'b1 || sv_data !== 32'd102) begin errors++; $display("FAIL rst_mid_beat3 got %b/%0d exp 1/102", sv_valid, sv_data); end
    #1 sys_rst_n = 1'b0;
    #1;
    checks++; if ({sv_valid, sv_last, state_vector_start, busy, cmd_ready} !== 5'b0 || stage_val !== 3'd0) begin
      errors++; $display("FAIL rst_mid_outputs got %b val %0d exp 00000/0", {sv_valid, sv_last, state_vector_start, busy, cmd_ready}, stage_val);
    end
    checks++; if ({vlr, rk, sv_data} !== '0) begin errors++; $display("FAIL rst_mid_data got nonzero exp 0"); end
    tick();
    sys_rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || sv_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release got rdy %b busy %b valid %b exp 1/0/0", cmd_ready, busy, sv_valid);
    end
  endtask

  initial begin
    test_reset();
    test_prd();
    test_operand_hold();
    test_stale_rdy();
    test_illegal();
    test_read(7);
    test_read(0);
    test_timeout();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
